// File: rtl/mac_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mac_ctrl_pkg : shared types and constants for the MAC tile sequencer      |
// | Rev 1.0 - initial release                                                 |
// +--------------------------------------------------------------------------+
package mac_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_KLOAD  = 3'd1,
      ST_KFLUSH = 3'd2,
      ST_EXEC   = 3'd3,
      ST_DRAIN  = 3'd4,
      ST_DONE   = 3'd5
   } state_t;

   localparam logic [1:0] INST_IDLE  = 2'b00;
   localparam logic [1:0] INST_KLOAD = 2'b01;
   localparam logic [1:0] INST_EXEC  = 2'b10;

   // Phase counter must hold row+col-1 as well as any act_len-1.
   function automatic int cnt_width(input int row_n, input int col_n, input int len_n);
      int w;
      w = $clog2(row_n + col_n);
      if (w < 1) w = 1;
      if (len_n > w) w = len_n;
      return w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mac_ctrl_cnt.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mac_ctrl_cnt : loadable down-counter with enable and zero flag            |
// | Rev 1.0 - initial release                                                 |
// +--------------------------------------------------------------------------+
module mac_ctrl_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_en,
   output logic         o_zero
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_en && (r_count != '0)) begin
         r_count <= r_count - W'(1);
      end
   end

   assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/mac_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mac_ctrl : xmem read sequencer and instruction driver for one tile pass   |
// | Rev 1.0 - initial release                                                 |
// +--------------------------------------------------------------------------+
module mac_ctrl
   import mac_ctrl_pkg::*;
#(
   parameter int row    = 8,
   parameter int col    = 8,
   parameter int addr_w = 11,
   parameter int len_w  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [addr_w-1:0] kernel_base,
   input  logic [addr_w-1:0] act_base,
   input  logic [len_w-1:0]  act_len,
   input  logic              ofifo_full,
   output logic              cen_xmem,
   output logic              wen_xmem,
   output logic [addr_w-1:0] a_xmem,
   output logic [1:0]        inst_w,
   output logic              busy,
   output logic              done
);

   localparam int CNT_W = cnt_width(row, col, len_w);

   localparam logic [CNT_W-1:0] c_row_ld   = CNT_W'(row - 1);
   localparam logic [CNT_W-1:0] c_col_ld   = CNT_W'(col - 1);
   localparam logic [CNT_W-1:0] c_drain_ld = CNT_W'(row + col - 1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_cen;
   logic              w_cen_nxt;
   logic [addr_w-1:0] r_a;
   logic [addr_w-1:0] w_a_nxt;
   logic [1:0]        r_inst;
   logic [1:0]        w_inst_nxt;
   logic              r_busy;
   logic              r_done;
   logic [addr_w-1:0] r_act_base;
   logic [len_w-1:0]  r_act_len;
   logic [len_w-1:0]  w_len_m1;
   logic              w_latch;
   logic              w_cnt_load;
   logic [CNT_W-1:0]  w_cnt_val;
   logic              w_cnt_en;
   logic              w_cnt_zero;

   assign w_len_m1 = r_act_len - len_w'(1);

   mac_ctrl_cnt #(
      .W (CNT_W)
   ) u_cnt (
      .clk        (clk),
      .rst        (reset),
      .i_load     (w_cnt_load),
      .i_load_val (w_cnt_val),
      .i_en       (w_cnt_en),
      .o_zero     (w_cnt_zero)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Outputs are computed for the next cycle, so r_cen/r_a describe the read
   // happening in the current state and r_inst trails them by one cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_cen_nxt   = 1'b1;
      w_a_nxt     = r_a;
      w_latch     = 1'b0;
      w_cnt_load  = 1'b0;
      w_cnt_val   = '0;
      w_cnt_en    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_latch     = 1'b1;
               w_state_nxt = ST_KLOAD;
               w_cnt_load  = 1'b1;
               w_cnt_val   = c_row_ld;
               w_a_nxt     = kernel_base;
               w_cen_nxt   = 1'b0;
            end
         end
         ST_KLOAD: begin
            if (w_cnt_zero) begin
               w_state_nxt = ST_KFLUSH;
               w_cnt_load  = 1'b1;
               w_cnt_val   = c_col_ld;
            end else begin
               w_cnt_en  = 1'b1;
               w_a_nxt   = r_a + addr_w'(1);
               w_cen_nxt = 1'b0;
            end
         end
         ST_KFLUSH: begin
            if (!w_cnt_zero) begin
               w_cnt_en = 1'b1;
            end else if (r_act_len != '0) begin
               w_state_nxt = ST_EXEC;
               w_cnt_load  = 1'b1;
               w_cnt_val   = CNT_W'(w_len_m1);
               w_a_nxt     = r_act_base;
               w_cen_nxt   = ofifo_full;
            end else begin
               w_state_nxt = ST_DRAIN;
               w_cnt_load  = 1'b1;
               w_cnt_val   = c_drain_ld;
            end
         end
         ST_EXEC: begin
            // Only a cycle that actually issued a read advances j.
            if (r_cen) begin
               w_cen_nxt = ofifo_full;
            end else if (w_cnt_zero) begin
               w_state_nxt = ST_DRAIN;
               w_cnt_load  = 1'b1;
               w_cnt_val   = c_drain_ld;
            end else begin
               w_cnt_en  = 1'b1;
               w_a_nxt   = r_a + addr_w'(1);
               w_cen_nxt = ofifo_full;
            end
         end
         ST_DRAIN: begin
            if (w_cnt_zero) begin
               w_state_nxt = ST_DONE;
            end else begin
               w_cnt_en = 1'b1;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      w_inst_nxt = INST_IDLE;
      if (!r_cen && (r_state == ST_KLOAD)) begin
         w_inst_nxt = INST_KLOAD;
      end else if (!r_cen && (r_state == ST_EXEC)) begin
         w_inst_nxt = INST_EXEC;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cen      <= 1'b1;
         r_a        <= '0;
         r_inst     <= INST_IDLE;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_act_base <= '0;
         r_act_len  <= '0;
      end else begin
         r_cen  <= w_cen_nxt;
         r_a    <= w_a_nxt;
         r_inst <= w_inst_nxt;
         r_busy <= (w_state_nxt != ST_IDLE);
         r_done <= (w_state_nxt == ST_DONE);
         if (w_latch) begin
            r_act_base <= act_base;
            r_act_len  <= act_len;
         end
      end
   end

   assign cen_xmem = r_cen;
   assign wen_xmem = 1'b1;
   assign a_xmem   = r_a;
   assign inst_w   = r_inst;
   assign busy     = r_busy;
   assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mac_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mac_ctrl : randomized bench for mac_ctrl against a schedule model      |
// | Rev 1.0 - initial release                                                 |
// +--------------------------------------------------------------------------+
module tb_mac_ctrl;

   localparam int ROW   = 8;
   localparam int COL   = 8;
   localparam int AW    = 11;
   localparam int LW    = 8;
   localparam int DEPTH = 512;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [AW-1:0] kernel_base;
   logic [AW-1:0] act_base;
   logic [LW-1:0] act_len;
   logic          ofifo_full;
   logic          cen_xmem;
   logic          wen_xmem;
   logic [AW-1:0] a_xmem;
   logic [1:0]    inst_w;
   logic          busy;
   logic          done;

   mac_ctrl #(
      .row    (ROW),
      .col    (COL),
      .addr_w (AW),
      .len_w  (LW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .kernel_base (kernel_base),
      .act_base    (act_base),
      .act_len     (act_len),
      .ofifo_full  (ofifo_full),
      .cen_xmem    (cen_xmem),
      .wen_xmem    (wen_xmem),
      .a_xmem      (a_xmem),
      .inst_w      (inst_w),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Expected per-cycle trace, indexed by cycle number relative to start (cycle 0).
   bit            ff     [DEPTH];
   bit            e_cen  [DEPTH];
   bit            e_achk [DEPTH];
   logic [AW-1:0] e_a    [DEPTH];
   logic [1:0]    e_inst [DEPTH];
   bit            e_busy [DEPTH];
   bit            e_done [DEPTH];
   int            e_last;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Schedule: row kernel reads, col idle, act_len reads skipping stalled
   // cycles, row+col idle, then one done cycle. Instruction trails each read.
   task automatic build_model(input logic [AW-1:0] kb, input logic [AW-1:0] ab, input int len);
      int t;
      int j;
      for (int i = 0; i < DEPTH; i++) begin
         e_cen[i]  = 1'b1;
         e_achk[i] = 1'b0;
         e_a[i]    = '0;
         e_inst[i] = 2'b00;
         e_busy[i] = 1'b0;
         e_done[i] = 1'b0;
      end
      t = 1;
      for (int k = 0; k < ROW; k++) begin
         e_cen[t]    = 1'b0;
         e_achk[t]   = 1'b1;
         e_a[t]      = kb + AW'(k);
         e_inst[t+1] = 2'b01;
         t++;
      end
      t += COL;
      j = 0;
      while (j < len) begin
         e_achk[t] = 1'b1;
         e_a[t]    = ab + AW'(j);
         if (!ff[t]) begin
            e_cen[t]    = 1'b0;
            e_inst[t+1] = 2'b10;
            j++;
         end
         t++;
      end
      t += ROW + COL;
      e_done[t] = 1'b1;
      for (int i = 1; i <= t; i++) e_busy[i] = 1'b1;
      e_last = t;
   endtask

   // smode: 0 no stall, 1 stall at cycles 18..20, 2 random stalls.
   // ign: 0 none, -1 random ignored starts, >0 ignored start in that cycle.
   // abort_at: >0 asserts reset asynchronously during that cycle.
   task automatic run_tile(input logic [AW-1:0] kb, input logic [AW-1:0] ab, input int len,
                           input int smode, input int ign, input int abort_at);
      int seen_done;
      for (int i = 0; i < DEPTH; i++) ff[i] = 1'b0;
      if (smode == 1) begin
         ff[18] = 1'b1;
         ff[19] = 1'b1;
         ff[20] = 1'b1;
      end else if (smode == 2) begin
         for (int i = 1; i < 300; i++) ff[i] = ($urandom_range(0, 3) == 0);
      end
      build_model(kb, ab, len);

      check_val("idle_busy", 32'(busy), 32'(0));
      check_val("idle_cen", 32'(cen_xmem), 32'(1));
      start       = 1'b1;
      kernel_base = kb;
      act_base    = ab;
      act_len     = LW'(len);
      ofifo_full  = ff[1];
      seen_done   = -1;

      for (int c = 1; c <= e_last + 1; c++) begin
         @(negedge clk);
         check_val($sformatf("cen@%0d", c), 32'(cen_xmem), 32'(e_cen[c]));
         check_val($sformatf("inst@%0d", c), 32'(inst_w), 32'(e_inst[c]));
         check_val($sformatf("busy@%0d", c), 32'(busy), 32'(e_busy[c]));
         check_val($sformatf("done@%0d", c), 32'(done), 32'(e_done[c]));
         check_val($sformatf("wen@%0d", c), 32'(wen_xmem), 32'(1));
         if (e_achk[c]) check_val($sformatf("addr@%0d", c), 32'(a_xmem), 32'(e_a[c]));
         if (done && seen_done < 0) seen_done = c;
         if (c == abort_at) begin
            #1;
            reset      = 1'b1;
            start      = 1'b0;
            ofifo_full = 1'b0;
            #1;
            check_val("arst_cen", 32'(cen_xmem), 32'(1));
            check_val("arst_addr", 32'(a_xmem), 32'(0));
            check_val("arst_inst", 32'(inst_w), 32'(0));
            check_val("arst_busy", 32'(busy), 32'(0));
            check_val("arst_done", 32'(done), 32'(0));
            @(negedge clk);
            reset = 1'b0;
            @(negedge clk);
            check_val("arst_idle_busy", 32'(busy), 32'(0));
            check_val("arst_idle_cen", 32'(cen_xmem), 32'(1));
            return;
         end
         start      = 1'b0;
         ofifo_full = ff[c+1];
         if ((ign == c) || (ign < 0 && c <= e_last && $urandom_range(0, 7) == 0)) begin
            start       = 1'b1;
            kernel_base = AW'($urandom);
            act_base    = AW'($urandom);
            act_len     = LW'($urandom);
         end
      end
      check_val("latency", 32'(seen_done), 32'(e_last));
      start      = 1'b0;
      ofifo_full = 1'b0;
   endtask

   initial begin
      reset       = 1'b0;
      start       = 1'b0;
      kernel_base = '0;
      act_base    = '0;
      act_len     = '0;
      ofifo_full  = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      check_val("rst_cen", 32'(cen_xmem), 32'(1));
      check_val("rst_wen", 32'(wen_xmem), 32'(1));
      check_val("rst_addr", 32'(a_xmem), 32'(0));
      check_val("rst_inst", 32'(inst_w), 32'(0));
      check_val("rst_busy", 32'(busy), 32'(0));
      check_val("rst_done", 32'(done), 32'(0));
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check_val("post_rst_busy", 32'(busy), 32'(0));
      check_val("post_rst_done", 32'(done), 32'(0));

      run_tile(11'h040, 11'h100, 4, 0, 0, 0);
      run_tile(11'h040, 11'h100, 4, 1, 0, 0);
      run_tile(11'h040, 11'h100, 0, 0, 0, 0);
      run_tile(11'h7FE, 11'h200, 3, 0, 12, 0);
      run_tile(11'h040, 11'h100, 4, 0, 0, 19);
      run_tile(11'h040, 11'h100, 4, 0, 0, 0);
      run_tile(11'h7FD, 11'h7FE, 5, 2, -1, 0);
      for (int n = 0; n < 12; n++) begin
         run_tile(AW'($urandom), AW'($urandom), int'($urandom_range(0, 60)), 2, -1, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mac_ctrl.md
# mac_ctrl

Sequencer for one `mac_row`/`mac_array` tile pass. It reads kernel words, then activation words, from the single-port activation/weight SRAM (xmem). It drives the 2-bit instruction bus (`inst_w[1]` = execute, `inst_w[0]` = kernel load) in the same cycle the SRAM read data reaches the array's west edge. After issuing, it waits out the array pipeline and signals completion. It sits between the top-level core and the xmem SRAM / MAC array, and applies back-pressure from the output FIFO.

## Interface
Parameters:
- `row`, 8: number of `mac_row` instances (kernel words per tile)
- `col`, 8: columns per row
- `addr_w`, 11: xmem address width
- `len_w`, 8: activation-length field width

Ports:
- `clk` in 1: clock
- `reset` in 1: asynchronous, active-high reset
- `start` in 1: single-cycle request to run one tile; honoured only in IDLE
- `kernel_base` in `addr_w`: first kernel word address; sampled with `start`
- `act_base` in `addr_w`: first activation word address; sampled with `start`
- `act_len` in `len_w`: number of activation vectors; sampled with `start`; 0 is legal
- `ofifo_full` in 1: output FIFO cannot accept; stalls execution issue
- `cen_xmem` out 1: SRAM chip enable, active low
- `wen_xmem` out 1: SRAM write enable, active low; tied high (read-only use)
- `a_xmem` out `addr_w`: SRAM address
- `inst_w` out 2: array instruction; 00 idle, 01 kernel load, 10 execute
- `busy` out 1: high from the cycle after an accepted `start` until IDLE is re-entered
- `done` out 1: one-cycle pulse at tile completion

## Operation
States: IDLE, KLOAD, KFLUSH, EXEC, DRAIN, DONE.

- **IDLE:** `cen_xmem`=1. When `start`=1, latch the bases and length, then go to KLOAD.
- **KLOAD:** `row` cycles. Each cycle: `cen_xmem`=0, `a_xmem`=`kernel_base`+k for k=0..`row`-1. Go to KFLUSH.
- **KFLUSH:** `col` cycles of no read. This lets the kernel-load instruction ripple through every column. Go to EXEC if latched length > 0, otherwise DRAIN.
- **EXEC:** issues `act_len` reads at `act_base`+j.
  - If `ofifo_full`=1 in a cycle: no read (`cen_xmem`=1), address and j hold, and that cycle does not count.
  - After the last issued read, go to DRAIN.
- **DRAIN:** `row`+`col` cycles, `cen_xmem`=1. Go to DONE.
- **DONE:** one cycle, `done`=1. Go to IDLE.

Rules:
- `inst_w` is the one-cycle-delayed image of the read phase: 01 the cycle after each KLOAD read, 10 the cycle after each EXEC read that was not stalled, 00 otherwise. This matches the 1-cycle SRAM read latency.
- Address arithmetic is modulo 2^`addr_w` (wraps silently).
- `start` is ignored outside IDLE. A `start` during the DONE cycle is ignored.
- Reset at any point returns to IDLE immediately. Any in-flight tile is abandoned.

## Timing
- Reset values: `cen_xmem`=1, `wen_xmem`=1, `a_xmem`=0, `inst_w`=00, `busy`=0, `done`=0. State is IDLE and all counters are 0.
- All outputs are registered; no combinational path from inputs to outputs.
- `ofifo_full` is sampled on the clock edge that would issue the read. A stall takes effect on `cen_xmem` in the same cycle and on `inst_w` one cycle later.
- With `start` in cycle 0:
  - KLOAD occupies cycles 1..`row`.
  - KFLUSH occupies the next `col` cycles.
  - EXEC occupies `act_len` + (stall cycles).
  - DRAIN occupies `row`+`col` cycles.
  - `done` follows.
  - Unstalled latency from `start` to `done` = 1+2·`row`+2·`col`+`act_len` cycles.

## Structure
- Package `mac_ctrl_pkg`:
  - state enum
  - instruction constants `INST_IDLE`=2'b00, `INST_KLOAD`=2'b01, `INST_EXEC`=2'b10
- One sub-module, `mac_ctrl_cnt`: a loadable down-counter with enable and zero flag. It is instantiated once and reloaded at each phase change (row, col, `act_len`, row+col).
- The top-level module holds the FSM, the address register and the `inst_w` delay register.

## Test plan
- **Reset:** assert `reset` mid-cycle with no clock → all outputs at their reset values. Release reset → remains IDLE, `busy`=0.
- **Basic tile:** `row`=`col`=8, `kernel_base`=0x040, `act_base`=0x100, `act_len`=4, `start` in cycle 0 → expect:
  - `a_xmem` 0x040..0x047 in cycles 1..8; `inst_w`=01 in cycles 2..9
  - `a_xmem` 0x100..0x103 in cycles 17..20; `inst_w`=10 in cycles 18..21
  - `done` in cycle 37; `busy` in cycles 1..37
- **Stall:** same as the basic tile, with `ofifo_full`=1 in cycles 18..20 → `a_xmem` holds 0x101 with `cen_xmem`=1 during the stall, and `inst_w`=00 in cycles 19..21. Then 0x101..0x103 issue in cycles 21..23, and `done` moves to cycle 40.
- **Zero length:** `act_len`=0 → no EXEC reads and no `inst_w`=10; `done` in cycle 33.
- **Wrap and ignored start:** `kernel_base`=0x7FE → addresses 0x7FE, 0x7FF, 0x000..0x005. A `start` pulse during KFLUSH causes no restart and no change in the latched parameters.
- **Mid-operation reset:** reset during EXEC → outputs return to reset values at once. A fresh `start` then reproduces the basic-tile sequence exactly.
